// File: rtl/sequenciador_etapas_pkg.sv
// rtl/sequenciador_etapas_pkg.sv - shared state encodings and stage helpers for the sequencer
//
// Purpose: single source for the stage encoding that is also exported on the
//          etapa port (0=IDLE 1=A 2=B 3=C), plus the fixed stage order.
// Contents: estado_t enum, proxima_etapa() helper.
package sequenciador_etapas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2,
    ST_C    = 2'd3
  } estado_t;

  // Stage order when a stage completes normally; C wraps back to IDLE.
  function automatic estado_t proxima_etapa(input estado_t e);
    case (e)
      ST_A:    return ST_B;
      ST_B:    return ST_C;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_etapas_sincroniza_borda.sv
// rtl/sequenciador_etapas_sincroniza_borda.sv - two-flop synchronizer with rising-edge pulse
//
// Purpose: bring an asynchronous level into the clk domain and emit a one-cycle
//          pulse on each 0->1 transition.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high; clears every flop
//   d      in  asynchronous level
//   pulso  out one-cycle pulse, high while s2 is 1 and the previous s2 was 0
module sincroniza_borda (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulso
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Combinational so the FSM consumes the pulse on the third edge after d rises.
  assign pulso = s2_q & ~prev_q;

endmodule

// File: rtl/sequenciador_etapas.sv
// rtl/sequenciador_etapas.sv - three-stage motor/valve/LED sequencer driven by divider ticks
//
// Purpose: IDLE -> A (motor) -> B (valve) -> C (LED) -> IDLE, each stage lasting
//          N_x rising edges of its base square wave (clk_2s/clk_4s/clk_8s).
// Ports:
//   clk, reset              50 MHz clock, asynchronous active-high reset
//   clk_2s, clk_4s, clk_8s  divider square waves, sampled as data
//   start, stop             asynchronous level requests, edge-triggered
//   motor, valvula, led     actuator enables (one-hot in A/B/C)
//   etapa                   encoded state
//   restante                N_x minus ticks counted in this stage; 0 in IDLE
//   busy, done              not-IDLE status; one-cycle completion pulse
module sequenciador_etapas
  import sequenciador_etapas_pkg::*;
#(
  parameter int unsigned N_A = 2,
  parameter int unsigned N_B = 1,
  parameter int unsigned N_C = 1,
  parameter int unsigned CW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_2s,
  input  logic          clk_4s,
  input  logic          clk_8s,
  input  logic          start,
  input  logic          stop,
  output logic          motor,
  output logic          valvula,
  output logic          led,
  output logic [1:0]    etapa,
  output logic [CW-1:0] restante,
  output logic          busy,
  output logic          done
);

  logic p2s, p4s, p8s, p_start, p_stop;

  sincroniza_borda u_sb_2s    (.clk(clk), .reset(reset), .d(clk_2s), .pulso(p2s));
  sincroniza_borda u_sb_4s    (.clk(clk), .reset(reset), .d(clk_4s), .pulso(p4s));
  sincroniza_borda u_sb_8s    (.clk(clk), .reset(reset), .d(clk_8s), .pulso(p8s));
  sincroniza_borda u_sb_start (.clk(clk), .reset(reset), .d(start),  .pulso(p_start));
  sincroniza_borda u_sb_stop  (.clk(clk), .reset(reset), .d(stop),   .pulso(p_stop));

  // Tick target of each stage; IDLE has none, so restante reads 0 there.
  function automatic logic [CW-1:0] limite(input estado_t e);
    case (e)
      ST_A:    return CW'(N_A);
      ST_B:    return CW'(N_B);
      ST_C:    return CW'(N_C);
      default: return '0;
    endcase
  endfunction

  estado_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] restante_d;
  logic          done_d;
  logic          tick;

  logic          motor_q, valvula_q, led_q, busy_q, done_q;
  logic [1:0]    etapa_q;
  logic [CW-1:0] restante_q;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    case (st_q)
      ST_A:    tick = p2s;
      ST_B:    tick = p4s;
      ST_C:    tick = p8s;
      default: tick = 1'b0;
    endcase
  end

  // Priority stop > tick > start; start is only looked at in IDLE, and stop
  // only outside IDLE.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (st_q == ST_IDLE) begin
      if (p_start) begin
        st_d  = ST_A;
        cnt_d = '0;
      end
    end else if (p_stop) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_inc == limite(st_q)) begin
        st_d   = proxima_etapa(st_q);
        cnt_d  = '0;
        done_d = (st_q == ST_C);
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // cnt_d is always below the limit of st_d, so this never wraps.
  assign restante_d = limite(st_d) - cnt_d;

  // Outputs decoded from the next state so they move on the same edge as st_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      motor_q    <= 1'b0;
      valvula_q  <= 1'b0;
      led_q      <= 1'b0;
      etapa_q    <= 2'd0;
      restante_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      motor_q    <= (st_d == ST_A);
      valvula_q  <= (st_d == ST_B);
      led_q      <= (st_d == ST_C);
      etapa_q    <= st_d;
      restante_q <= restante_d;
      busy_q     <= (st_d != ST_IDLE);
      done_q     <= done_d;
    end
  end

  assign motor    = motor_q;
  assign valvula  = valvula_q;
  assign led      = led_q;
  assign etapa    = etapa_q;
  assign restante = restante_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sequenciador_etapas.sv
// tb/tb_sequenciador_etapas.sv - directed self-checking bench for sequenciador_etapas
module tb_sequenciador_etapas;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_2s = 1'b0, clk_4s = 1'b0, clk_8s = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic          motor, valvula, led, busy, done;
  logic [1:0]    etapa;
  logic [CW-1:0] restante;

  int testes = 0;
  int falhas = 0;
  int n_done = 0;

  sequenciador_etapas #(.N_A(2), .N_B(1), .N_C(1), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .clk_2s(clk_2s), .clk_4s(clk_4s), .clk_8s(clk_8s),
    .start(start), .stop(stop),
    .motor(motor), .valvula(valvula), .led(led),
    .etapa(etapa), .restante(restante), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  // Count every done pulse, sampled away from the edge.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) n_done++;
  end

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Packed view: {motor, valvula, led, busy, done, etapa[1:0], restante[3:0]}
  function automatic logic [31:0] saidas();
    return {21'd0, motor, valvula, led, busy, done, etapa, restante};
  endfunction

  function automatic logic [31:0] esperado(input logic m, v, l, b, d,
                                           input logic [1:0] e, input logic [3:0] r);
    return {21'd0, m, v, l, b, d, e, r};
  endfunction

  task automatic set_in(input int k, input logic v);
    case (k)
      0: start  = v;
      1: stop   = v;
      2: clk_2s = v;
      3: clk_4s = v;
      default: clk_8s = v;
    endcase
  endtask

  // Raise one or two inputs at a falling edge, then sit just after the third rising edge.
  task automatic borda(input int k1, input int k2);
    @(negedge clk);
    set_in(k1, 1'b1);
    if (k2 >= 0) set_in(k2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic solta(input int k1, input int k2);
    @(negedge clk);
    set_in(k1, 1'b0);
    if (k2 >= 0) set_in(k2, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulso(input int k);
    borda(k, -1);
    solta(k, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #5;
    checar("reset_state", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: start -> A exactly 3 cycles later, not 2
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checar("start_lat2", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    checar("start_lat3", saidas(), esperado(1,0,0,1,0,2'd1,4'd2));
    solta(0, -1);

    // 2: full run; a clk_4s edge during A must be ignored
    borda(3, -1);
    checar("A_ignores_4s", saidas(), esperado(1,0,0,1,0,2'd1,4'd2));
    solta(3, -1);
    borda(2, -1);
    checar("A_tick1", saidas(), esperado(1,0,0,1,0,2'd1,4'd1));
    solta(2, -1);
    borda(2, -1);
    checar("A_to_B", saidas(), esperado(0,1,0,1,0,2'd2,4'd1));
    solta(2, -1);
    borda(3, -1);
    checar("B_to_C", saidas(), esperado(0,0,1,1,0,2'd3,4'd1));
    solta(3, -1);
    borda(4, -1);
    checar("C_done", saidas(), esperado(0,0,0,0,1,2'd0,4'd0));
    @(posedge clk);
    #1;
    checar("done_width", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    solta(4, -1);
    checar("done_count_run", n_done, 1);

    // 3: stop during B
    pulso(0);
    pulso(2);
    borda(2, -1);
    checar("in_B", saidas(), esperado(0,1,0,1,0,2'd2,4'd1));
    solta(2, -1);
    borda(1, -1);
    checar("stop_in_B", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    solta(1, -1);
    checar("stop_no_done", n_done, 1);

    // 4a: stop and clk_2s edge together in A with counter=1 -> IDLE, not B
    pulso(0);
    pulso(2);
    checar("A_cnt1", saidas(), esperado(1,0,0,1,0,2'd1,4'd1));
    borda(1, 2);
    checar("stop_beats_tick", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    solta(1, 2);
    // 4b: start and stop together in IDLE -> A
    borda(0, 1);
    checar("start_stop_idle", saidas(), esperado(1,0,0,1,0,2'd1,4'd2));
    solta(0, 1);
    pulso(1);
    checar("stop_cleanup", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));

    // 5: start held through a full run -> no automatic second run
    borda(0, -1);
    checar("held_start_A", {30'd0, etapa}, 32'd1);
    pulso(2);
    pulso(2);
    pulso(3);
    pulso(4);
    repeat (10) @(negedge clk);
    checar("held_no_rerun", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    checar("held_done_count", n_done, 2);
    solta(0, -1);
    borda(0, -1);
    checar("new_edge_rerun", saidas(), esperado(1,0,0,1,0,2'd1,4'd2));
    solta(0, -1);

    // 6: asynchronous reset while in C
    pulso(2);
    pulso(2);
    pulso(3);
    checar("in_C", saidas(), esperado(0,0,1,1,0,2'd3,4'd1));
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    checar("async_reset_C", saidas(), esperado(0,0,0,0,0,2'd0,4'd0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checar("reset_no_done", n_done, 2);
    pulso(0);
    checar("restart_A", saidas(), esperado(1,0,0,1,0,2'd1,4'd2));
    pulso(2);
    pulso(2);
    pulso(3);
    borda(4, -1);
    checar("restart_done", saidas(), esperado(0,0,0,0,1,2'd0,4'd0));
    solta(4, -1);
    checar("final_done_count", n_done, 3);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
